// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants and helpers used by the controller,
// the branch-metric unit and every ACS node.
package viterbi_pkg;

  // Default path-metric width.
  localparam int PM_W_DEFAULT = 8;

  // Branch metrics are 2-bit Hamming distances. 0..2 are legal; 3 is never
  // produced by the branch-metric unit.
  localparam int BM_W   = 2;
  localparam int BM_MAX = 2;

  // Normalisation step: half the metric range.
  function automatic int norm_of(input int w);
    return 1 << (w - 1);
  endfunction

  // Largest representable path metric.
  function automatic int pm_max_of(input int w);
    return (1 << w) - 1;
  endfunction

  // Metric loaded at frame start. The trellis start state begins at 0; every
  // other state begins half a range away so it cannot win early comparisons.
  function automatic int init_pm_of(input int w, input bit zero);
    return zero ? 0 : norm_of(w);
  endfunction

endpackage

// File: rtl/acs_cmp.sv
// Combinational add-compare-select: one extra bit of headroom so that
// the sums never wrap; ties resolve towards predecessor A.
module acs_cmp
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEFAULT
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [BM_W-1:0] bm_a,
  input  logic [BM_W-1:0] bm_b,
  output logic [PM_W:0]   sel,
  output logic            decision_next
);

  logic [PM_W:0] cand_a;
  logic [PM_W:0] cand_b;

  // Extend both metrics by one bit before adding so the sum cannot wrap.
  always_comb begin
    cand_a        = {1'b0, pm_a} + {{(PM_W + 1 - BM_W){1'b0}}, bm_a};
    cand_b        = {1'b0, pm_b} + {{(PM_W + 1 - BM_W){1'b0}}, bm_b};
    decision_next = (cand_b < cand_a);
    sel           = decision_next ? cand_b : cand_a;
  end

endmodule

// File: rtl/acs_node.sv
// One trellis state of the Viterbi decoder: registers the survivor metric
// and decision, applies global normalisation, saturates on overflow and
// tracks a two-state IDLE/RUN control that drives out_valid.
module acs_node
  import viterbi_pkg::*;
#(
  parameter int PM_W      = PM_W_DEFAULT,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            in_valid,
  input  logic            norm_en,
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [BM_W-1:0] bm_a,
  input  logic [BM_W-1:0] bm_b,
  output logic [PM_W-1:0] pm_out,
  output logic            decision,
  output logic            out_valid,
  output logic            sat_flag
);

  localparam logic [PM_W:0]   NORM_EXT   = (PM_W + 1)'(norm_of(PM_W));
  localparam logic [PM_W:0]   PM_MAX_EXT = (PM_W + 1)'(pm_max_of(PM_W));
  localparam logic [PM_W-1:0] INIT_VAL   = PM_W'(init_pm_of(PM_W, INIT_ZERO));

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [PM_W:0]   cmp_sel;
  logic            cmp_decision;
  logic [PM_W:0]   post_val;
  logic            sat_hit;

  logic [PM_W-1:0] pm_reg, pm_next;
  logic            decision_reg, decision_next;
  logic            sat_reg, sat_next;
  logic [0:0]      state_reg, state_next;

  acs_cmp #(
    .PM_W(PM_W)
  ) u_acs_cmp (
    .pm_a          (pm_a),
    .pm_b          (pm_b),
    .bm_a          (bm_a),
    .bm_b          (bm_b),
    .sel           (cmp_sel),
    .decision_next (cmp_decision)
  );

  // Normalise the selected metric (floor at zero), then detect overflow.
  always_comb begin
    post_val = cmp_sel;
    if (norm_en) begin
      post_val = (cmp_sel >= NORM_EXT) ? (cmp_sel - NORM_EXT) : '0;
    end
    sat_hit = (post_val > PM_MAX_EXT);
  end

  // Next-state selection: frame_start wins, then a valid symbol, else hold.
  always_comb begin
    pm_next       = pm_reg;
    decision_next = decision_reg;
    sat_next      = sat_reg;
    state_next    = ST_IDLE;
    if (frame_start) begin
      pm_next       = INIT_VAL;
      decision_next = 1'b0;
      sat_next      = 1'b0;
      state_next    = ST_IDLE;
    end else if (in_valid) begin
      pm_next       = sat_hit ? PM_MAX_EXT[PM_W-1:0] : post_val[PM_W-1:0];
      decision_next = cmp_decision;
      sat_next      = sat_reg | sat_hit;
      state_next    = ST_RUN;
    end
  end

  // State registers; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_reg       <= INIT_VAL;
      decision_reg <= 1'b0;
      sat_reg      <= 1'b0;
      state_reg    <= ST_IDLE;
    end else begin
      pm_reg       <= pm_next;
      decision_reg <= decision_next;
      sat_reg      <= sat_next;
      state_reg    <= state_next;
    end
  end

  assign pm_out    = pm_reg;
  assign decision  = decision_reg;
  assign sat_flag  = sat_reg;
  assign out_valid = (state_reg == ST_RUN);

endmodule

// File: tb/tb_acs_node.sv
// Bench for acs_node: two instances (INIT_ZERO=0 and 1) share stimulus and
// are compared every cycle against an integer reference model.
module tb_acs_node;

  localparam int PM_W = 8;
  localparam int NORM = 128;
  localparam int PMAX = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       in_valid = 1'b0;
  logic       norm_en = 1'b0;
  logic [7:0] pm_a = '0;
  logic [7:0] pm_b = '0;
  logic [1:0] bm_a = '0;
  logic [1:0] bm_b = '0;

  logic [7:0] pm_out0, pm_out1;
  logic       decision0, decision1;
  logic       out_valid0, out_valid1;
  logic       sat0, sat1;

  int n_checks = 0;
  int n_pass   = 0;

  int m_pm  [2];
  int m_dec [2];
  int m_ov  [2];
  int m_sat [2];

  always #5 clk = ~clk;

  acs_node #(.PM_W(PM_W), .INIT_ZERO(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .norm_en(norm_en), .pm_a(pm_a), .pm_b(pm_b), .bm_a(bm_a), .bm_b(bm_b),
    .pm_out(pm_out0), .decision(decision0), .out_valid(out_valid0), .sat_flag(sat0)
  );

  acs_node #(.PM_W(PM_W), .INIT_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .norm_en(norm_en), .pm_a(pm_a), .pm_b(pm_b), .bm_a(bm_a), .bm_b(bm_b),
    .pm_out(pm_out1), .decision(decision1), .out_valid(out_valid1), .sat_flag(sat1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reset / frame-start value of each instance: instance 1 is the start state.
  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pm[i]  = (i == 1) ? 0 : NORM;
      m_dec[i] = 0;
      m_ov[i]  = 0;
      m_sat[i] = 0;
    end
  endfunction

  // Behaviour at a rising edge, from the current inputs.
  function automatic void model_clock();
    int ca, cb, s;
    for (int i = 0; i < 2; i++) begin
      if (frame_start) begin
        m_pm[i]  = (i == 1) ? 0 : NORM;
        m_dec[i] = 0;
        m_ov[i]  = 0;
        m_sat[i] = 0;
      end else if (in_valid) begin
        ca = int'(pm_a) + int'(bm_a);
        cb = int'(pm_b) + int'(bm_b);
        m_dec[i] = (cb < ca) ? 1 : 0;
        s = (cb < ca) ? cb : ca;
        if (norm_en) s = (s - NORM < 0) ? 0 : s - NORM;
        if (s > PMAX) begin
          s = PMAX;
          m_sat[i] = 1;
        end
        m_pm[i] = s;
        m_ov[i] = 1;
      end else begin
        m_ov[i] = 0;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/pm0"},  pm_out0,    m_pm[0]);
    check({tag, "/dec0"}, decision0,  m_dec[0]);
    check({tag, "/ov0"},  out_valid0, m_ov[0]);
    check({tag, "/sat0"}, sat0,       m_sat[0]);
    check({tag, "/pm1"},  pm_out1,    m_pm[1]);
    check({tag, "/dec1"}, decision1,  m_dec[1]);
    check({tag, "/ov1"},  out_valid1, m_ov[1]);
    check({tag, "/sat1"}, sat1,       m_sat[1]);
  endtask

  task automatic cycle(input string tag, input bit fs, input bit iv, input bit ne,
                       input int pa, input int pb, input int ba, input int bb);
    frame_start = fs;
    in_valid    = iv;
    norm_en     = ne;
    pm_a        = 8'(pa);
    pm_b        = 8'(pb);
    bm_a        = 2'(ba);
    bm_b        = 2'(bb);
    @(posedge clk);
    model_clock();
    #1;
    $display("%s fs=%0b iv=%0b ne=%0b pa=%0d bma=%0d pb=%0d bmb=%0d -> pm0=%0d pm1=%0d dec=%0b ov=%0b sat=%0b",
             tag, fs, iv, ne, pa, ba, pb, bb, pm_out0, pm_out1, decision1, out_valid1, sat1);
    check_all(tag);
  endtask

  initial begin
    // Reset held across two edges.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 1'b0;

    cycle("fstart", 1, 0, 0, 0, 0, 0, 0);
    check("fstart_pm_zero", pm_out1, 0);
    check("fstart_pm_init", pm_out0, 128);

    cycle("first", 0, 1, 0, 0, 128, 2, 0);
    check("first_pm", pm_out1, 2);
    check("first_dec", decision1, 0);
    check("first_ov", out_valid1, 1);

    cycle("tie", 0, 1, 0, 10, 9, 1, 2);
    check("tie_pm", pm_out1, 11);
    check("tie_dec", decision1, 0);

    cycle("norm", 0, 1, 1, 200, 210, 1, 0);
    check("norm_pm", pm_out1, 73);
    check("norm_dec", decision1, 0);

    cycle("clamp", 0, 1, 1, 5, 255, 0, 2);
    check("clamp_pm", pm_out1, 0);

    cycle("sat", 0, 1, 0, 254, 255, 2, 2);
    check("sat_pm", pm_out1, 255);
    check("sat_flag", sat1, 1);

    cycle("idle", 0, 0, 0, 1, 1, 0, 0);
    check("idle_ov", out_valid1, 0);
    check("idle_hold", pm_out1, 255);

    cycle("fs_iv", 1, 1, 0, 3, 3, 0, 0);
    check("fs_iv_ov", out_valid0, 0);
    check("fs_iv_pm", pm_out0, 128);
    check("fs_iv_sat", sat0, 0);

    // Randomised traffic, including the illegal branch metric 3.
    for (int k = 0; k < 150; k++) begin
      cycle("rand",
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset between edges while a symbol stream is running.
    frame_start = 1'b0;
    in_valid    = 1'b1;
    norm_en     = 1'b0;
    pm_a        = 8'd40;
    pm_b        = 8'd50;
    bm_a        = 2'd1;
    bm_b        = 2'd0;
    @(posedge clk);
    model_clock();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #2;
    rst = 1'b0;

    cycle("burst0", 0, 1, 0, 20, 30, 2, 1);
    check("burst0_ov", out_valid0, 1);
    cycle("burst1", 0, 1, 0, 30, 20, 2, 1);
    check("burst1_ov", out_valid0, 1);
    cycle("burst2", 0, 1, 1, 250, 240, 0, 2);
    check("burst2_ov", out_valid0, 1);
    cycle("after", 0, 0, 0, 0, 0, 0, 0);
    check("after_ov", out_valid0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
